// File: rtl/new_feature_writer.sv
`default_nettype none
// ============================================================================
//  Module      : new_feature_writer
//  Description : Sink-side writer for the layer's output features. Accepts one
//                packed feature vector per subgraph over valid/ready, buffers
//                vectors in a small FIFO and serializes each vector element by
//                element into the new-feature BRAM in row-major order. Raises
//                a sticky done once NUM_SUBGRAPHS vectors have been written.
//                Optional macro NEW_FEATURE_RELU_EN clamps negative elements
//                to zero on the registered write path.
//  Revision    : 1.0 - initial release
// ============================================================================
module new_feature_writer #(
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int NUM_SUBGRAPHS     = 2708,
    parameter int FIFO_DEPTH        = 4,
    localparam int NEW_FEATURE_ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT),
    localparam int NODE_CNT_W         = $clog2(NUM_SUBGRAPHS + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         feat_vld_i,
    output logic                                         feat_rdy_o,
    input  logic [NUM_FEATURE_OUT*NEW_FEATURE_WIDTH-1:0] feat_i,
    output logic                                         bram_ena,
    output logic                                         bram_wea,
    output logic [NEW_FEATURE_ADDR_W-1:0]                bram_addra,
    output logic [NEW_FEATURE_WIDTH-1:0]                 bram_dina,
    output logic [NODE_CNT_W-1:0]                        node_cnt_o,
    output logic                                         done_o
);

    localparam int c_VEC_W = NUM_FEATURE_OUT * NEW_FEATURE_WIDTH;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_IDX_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;

    localparam logic [c_IDX_W-1:0]    c_LAST_IDX  = c_IDX_W'(NUM_FEATURE_OUT - 1);
    localparam logic [c_OCC_W-1:0]    c_FULL_OCC  = c_OCC_W'(FIFO_DEPTH);
    localparam logic [c_OCC_W-1:0]    c_ONE_OCC   = c_OCC_W'(1);
    localparam logic [NODE_CNT_W-1:0] c_LAST_NODE = NODE_CNT_W'(NUM_SUBGRAPHS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic [c_VEC_W-1:0]            r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]            r_wr_ptr;
    logic [c_PTR_W-1:0]            r_rd_ptr;
    logic [c_OCC_W-1:0]            r_occ;
    logic                          r_run;
    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_IDX_W-1:0]            r_idx;
    logic [c_IDX_W-1:0]            w_idx_nxt;
    logic [c_IDX_W-1:0]            w_cur_idx;
    logic [c_VEC_W-1:0]            r_out_vec;
    logic [c_VEC_W-1:0]            w_head;
    logic [c_VEC_W-1:0]            w_src_vec;
    logic [NEW_FEATURE_ADDR_W-1:0] r_addr_cnt;
    logic [NODE_CNT_W-1:0]         w_issued_cnt;
    logic [NEW_FEATURE_WIDTH-1:0]  w_elem;
    logic [NEW_FEATURE_WIDTH-1:0]  w_elem_wr;
    logic                          r_last_wr;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_head_issue;
    logic                          w_issue;
    logic                          w_is_last;
    logic                          w_more;

    // Ready is gated by done_o rather than the DONE state so that it falls in
    // the same cycle done_o rises; r_run holds it low until reset is released.
    assign w_full     = (r_occ == c_FULL_OCC);
    assign w_empty    = (r_occ == '0);
    assign feat_rdy_o = r_run && !w_full && !done_o;
    assign w_push     = feat_vld_i && feat_rdy_o;
    assign w_head     = r_fifo_mem[r_rd_ptr];
    assign w_pop      = w_head_issue;

    // Vectors finished or with their last element already on the BRAM port.
    assign w_issued_cnt = node_cnt_o + NODE_CNT_W'(r_last_wr);

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= feat_i;
        end
    end

    // FIFO pointers, occupancy and the post-reset run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_run    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Next-state logic. Element 0 is taken straight from the FIFO head in the
    // pop cycle so it reaches the registered port one edge after the pop.
    // WRITE with index 0 means "pop the next vector now" (no bubble).
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_head_issue = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_head_issue = !w_empty;
                w_issue      = !w_empty;
            end
            S_WRITE: begin
                w_head_issue = (r_idx == '0);
                w_issue      = 1'b1;
            end
            default: begin
                w_head_issue = 1'b0;
                w_issue      = 1'b0;
            end
        endcase
        w_cur_idx = w_head_issue ? '0 : r_idx;
        w_src_vec = w_head_issue ? w_head : r_out_vec;
        w_is_last = w_issue && (w_cur_idx == c_LAST_IDX);
        w_more    = w_head_issue ? (r_occ > c_ONE_OCC) : !w_empty;
        if (w_is_last) begin
            w_idx_nxt = '0;
            if (w_issued_cnt == c_LAST_NODE) begin
                w_state_nxt = S_DONE;
            end else if (w_more) begin
                w_state_nxt = S_WRITE;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else if (w_issue) begin
            w_idx_nxt   = w_cur_idx + 1'b1;
            w_state_nxt = S_WRITE;
        end
    end

    // Element select mux over the current vector.
    always_comb begin
        w_elem = '0;
        for (int e = 0; e < NUM_FEATURE_OUT; e++) begin
            if (w_cur_idx == c_IDX_W'(e)) begin
                w_elem = w_src_vec[e*NEW_FEATURE_WIDTH +: NEW_FEATURE_WIDTH];
            end
        end
    end

`ifdef NEW_FEATURE_RELU_EN
    assign w_elem_wr = w_elem[NEW_FEATURE_WIDTH-1] ? '0 : w_elem;
`else
    assign w_elem_wr = w_elem;
`endif

    // State register and the vector being serialized.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_out_vec <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_head_issue) begin
                r_out_vec <= w_head;
            end
        end
    end

    // Registered BRAM port, running address and completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            r_addr_cnt <= '0;
            r_last_wr  <= 1'b0;
            node_cnt_o <= '0;
            done_o     <= 1'b0;
        end else begin
            bram_ena  <= w_issue;
            bram_wea  <= w_issue;
            r_last_wr <= w_is_last;
            if (w_issue) begin
                bram_addra <= r_addr_cnt;
                bram_dina  <= w_elem_wr;
                r_addr_cnt <= r_addr_cnt + 1'b1;
            end
            if (r_last_wr) begin
                node_cnt_o <= node_cnt_o + 1'b1;
                if (node_cnt_o == c_LAST_NODE) begin
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_new_feature_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_new_feature_writer
//  Description : Self-checking bench for new_feature_writer. A reference
//                schedule derived from accept times predicts every BRAM write,
//                node count, done and ready each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_new_feature_writer;

    localparam int W     = 32;
    localparam int N     = 4;
    localparam int NUM   = 3;
    localparam int DEPTH = 2;
    localparam int AW    = $clog2(NUM * N);
    localparam int CW    = $clog2(NUM + 1);
    localparam int VW    = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          feat_vld_i;
    logic          feat_rdy_o;
    logic [VW-1:0] feat_i;
    logic          bram_ena;
    logic          bram_wea;
    logic [AW-1:0] bram_addra;
    logic [W-1:0]  bram_dina;
    logic [CW-1:0] node_cnt_o;
    logic          done_o;

    new_feature_writer #(
        .NEW_FEATURE_WIDTH (W),
        .NUM_FEATURE_OUT   (N),
        .NUM_SUBGRAPHS     (NUM),
        .FIFO_DEPTH        (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_vld_i (feat_vld_i),
        .feat_rdy_o (feat_rdy_o),
        .feat_i     (feat_i),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .node_cnt_o (node_cnt_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: accept edge per vector, first-write cycle per scheduled
    // vector (only the first NUM get written), and the accepted data.
    int            acc_t[$];
    int            st[$];
    logic [VW-1:0] vq[$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_elem(input logic [VW-1:0] v, input int e);
        logic [W-1:0] x;
        x = v[e*W +: W];
`ifdef NEW_FEATURE_RELU_EN
        if ($signed(x) < 0) x = '0;
`endif
        return x;
    endfunction

    function automatic bit model_rdy();
        int occ;
        int fin;
        occ = 0;
        fin = 0;
        foreach (acc_t[i]) if (acc_t[i] <= cyc) occ++;
        foreach (st[i]) begin
            if (st[i] <= cyc) occ--;
            if (st[i] + N <= cyc) fin++;
        end
        return (cyc >= 1) && (occ < DEPTH) && (fin < NUM);
    endfunction

    function automatic logic [VW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [VW-1:0] v;
        v = '0;
        v[0*W +: W] = a0;
        v[1*W +: W] = a1;
        v[2*W +: W] = a2;
        v[3*W +: W] = a3;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int e = 0; e < N; e++) v[e*W +: W] = $urandom;
        return v;
    endfunction

    task automatic check_outputs();
        logic          ew;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        int            en;
        ew = 1'b0;
        ea = '0;
        ed = '0;
        en = 0;
        foreach (st[k]) begin
            if (cyc >= st[k] && cyc < st[k] + N) begin
                ew = 1'b1;
                ea = AW'(k * N + cyc - st[k]);
                ed = ref_elem(vq[k], cyc - st[k]);
            end
            if (st[k] + N <= cyc) en++;
        end
        check_val("wea", bram_wea, ew);
        check_val("ena", bram_ena, ew);
        if (ew) begin
            check_val("addra", bram_addra, ea);
            check_val("dina", bram_dina, ed);
        end
        check_val("node_cnt", node_cnt_o, en);
        check_val("done", done_o, en == NUM);
        check_val("rdy", feat_rdy_o, model_rdy());
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, "_rdy"},  feat_rdy_o, 0);
        check_val({pfx, "_ena"},  bram_ena,   0);
        check_val({pfx, "_wea"},  bram_wea,   0);
        check_val({pfx, "_addr"}, bram_addra, 0);
        check_val({pfx, "_dina"}, bram_dina,  0);
        check_val({pfx, "_node"}, node_cnt_o, 0);
        check_val({pfx, "_done"}, done_o,     0);
    endtask

    // One clock: drive inputs, record acceptance in the model, check outputs
    // on the following falling edge.
    task automatic cycle(input logic vld, input logic [VW-1:0] data);
        int a;
        int s;
        feat_vld_i = vld;
        feat_i     = data;
        if (vld && model_rdy()) begin
            a = cyc + 1;
            acc_t.push_back(a);
            vq.push_back(data);
            if (st.size() < NUM) begin
                s = a + 1;
                if (st.size() > 0 && st[st.size()-1] + N > s) s = st[st.size()-1] + N;
                st.push_back(s);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset(input int hold);
        feat_vld_i = 1'b0;
        feat_i     = '0;
        rst_n      = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (hold) @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        acc_t.delete();
        st.delete();
        vq.delete();
        cyc = 0;
        #1;
        check_outputs();
        cycle(1'b0, '0);
    endtask

    initial begin
        logic [VW-1:0] v;
        logic          vl;
        bit            r;
        bit            found;

        rst_n      = 1'b1;
        feat_vld_i = 1'b0;
        feat_i     = '0;
        #2;
        apply_reset(3);

        // Single vector, then idle.
        cycle(1'b1, pack4(1, 2, 3, 4));
        repeat (8) cycle(1'b0, '0);
        check_val("s1_node", node_cnt_o, 1);
        check_val("s1_done", done_o, 0);

        // Valid held: FIFO fills, back-to-back writes, done.
        apply_reset(2);
        v = rand_vec();
        repeat (14) begin
            r = model_rdy();
            cycle(1'b1, v);
            if (r) v = rand_vec();
        end
        repeat (10) cycle(1'b0, '0);
        check_val("s2_done", done_o, 1);
        check_val("s2_node", node_cnt_o, 3);
        check_val("s2_rdy", feat_rdy_o, 0);

        // Widely spaced vectors.
        apply_reset(2);
        repeat (3) begin
            cycle(1'b1, rand_vec());
            repeat (20) cycle(1'b0, '0);
        end
        check_val("s3_done", done_o, 1);

        // Reset in the middle of the second vector.
        apply_reset(2);
        cycle(1'b1, rand_vec());
        cycle(1'b1, rand_vec());
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bram_wea && bram_addra == AW'(5)) found = 1'b1;
            else cycle(1'b0, '0);
        end
        check_val("s4_addr5_seen", found, 1);
        apply_reset(2);
        cycle(1'b1, pack4(5, 6, 7, 8));
        repeat (8) cycle(1'b0, '0);
        check_val("s4_node", node_cnt_o, 1);

        // Negative, positive and zero elements.
        cycle(1'b1, pack4(-1, 5, -128, 0));
        repeat (8) cycle(1'b0, '0);
        check_val("s5_node", node_cnt_o, 2);

        // Randomized traffic with occasional resets.
        for (int run = 0; run < 6; run++) begin
            apply_reset(1 + int'($urandom_range(0, 2)));
            v = rand_vec();
            for (int c = 0; c < 50; c++) begin
                if ($urandom_range(0, 39) == 0) begin
                    apply_reset(1);
                    v = rand_vec();
                end
                vl = ($urandom_range(0, 2) != 0);
                r  = model_rdy();
                cycle(vl, v);
                if (vl && r) v = rand_vec();
            end
            repeat (20) cycle(1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
